// File: rtl/adder_pipe.sv
// Purpose: pipelined WIDTH-bit adder/subtractor, carry chain split into STAGES chunks.
// Latency: STAGES cycles from accept to out_valid; one result per cycle.
// Backpressure: the whole pipe stalls when out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Ports: clk/rst_n (async active-low); in_valid/in_ready + a, b, cin, sub operand handshake;
//        out_valid/out_ready + s, cout, ovf result handshake.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Stage registers. Operand words travel whole down the pipe (skew), the
  // sum word fills in one chunk per stage (deskew); unused low operand
  // chunks and high sum chunks are constant-folded away by synthesis.
  logic             vld_q [STAGES];
  logic             cry_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic             ovf_q;

  // Per-stage inputs (stage 0 from the ports, stage k from stage k-1).
  logic             vld_in  [STAGES];
  logic             cry_in  [STAGES];
  logic [WIDTH-1:0] sum_in  [STAGES];
  logic [WIDTH-1:0] opa_in  [STAGES];
  logic [WIDTH-1:0] opb_in  [STAGES];
  logic [CHUNK:0]   part    [STAGES];
  logic [WIDTH-1:0] sum_nxt [STAGES];
  logic             ovf_nxt;
  logic             adv;

  function automatic logic [WIDTH-1:0] merge_chunk(input logic [WIDTH-1:0] word,
                                                   input logic [CHUNK-1:0] chunk,
                                                   input int               idx);
    logic [WIDTH-1:0] r;
    r = word;
    r[idx*CHUNK +: CHUNK] = chunk;
    return r;
  endfunction

  // Single global advance: every stage moves together, bubbles included.
  assign adv      = !vld_q[LAST] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_src
      // Subtract is a + ~b + ~cin; inversion happens once at entry so the
      // modified operand and carry travel with their transaction.
      assign vld_in[k] = in_valid;
      assign cry_in[k] = cin ^ sub;
      assign sum_in[k] = '0;
      assign opa_in[k] = a;
      assign opb_in[k] = b ^ {WIDTH{sub}};
    end else begin : g_src
      assign vld_in[k] = vld_q[k-1];
      assign cry_in[k] = cry_q[k-1];
      assign sum_in[k] = sum_q[k-1];
      assign opa_in[k] = opa_q[k-1];
      assign opb_in[k] = opb_q[k-1];
    end

    assign part[k] = {1'b0, opa_in[k][k*CHUNK +: CHUNK]}
                   + {1'b0, opb_in[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cry_in[k]};
    assign sum_nxt[k] = merge_chunk(sum_in[k], part[k][CHUNK-1:0], k);
  end

  // Overflow is only knowable once the top chunk is summed in the last stage.
  assign ovf_nxt = (opa_in[LAST][WIDTH-1] == opb_in[LAST][WIDTH-1]) &&
                   (sum_nxt[LAST][WIDTH-1] != opa_in[LAST][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        sum_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_in[k];
        cry_q[k] <= part[k][CHUNK];
        sum_q[k] <= sum_nxt[k];
        opa_q[k] <= opa_in[k];
        opb_q[k] <= opb_in[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

  assign out_valid = vld_q[LAST];
  assign s         = sum_q[LAST];
  assign cout      = cry_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (WIDTH=16, STAGES=4): directed steps, model-driven scoreboard.
// Inputs change 1 time unit after rising edges; DUT is sampled on falling edges.
// Ports: drives every DUT input, observes every DUT output.
module tb_adder_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] got_s[$];
  logic        ov_hist [0:4095];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          last_acc = 0;
  int          last_lat = 0;
  logic [15:0] last_s = '0;
  logic        last_cout = 1'b0;
  logic        last_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,s} = a + (b or ~b) + (cin or ~cin); ovf from operand/result signs.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms, input int c);
    exp_t        e;
    logic [15:0] bb;
    logic        cc;
    logic [16:0] r;
    bb    = ms ? ~mb : mb;
    cc    = ms ? ~mc : mc;
    r     = {1'b0, ma} + {1'b0, bb} + {16'd0, cc};
    e.s    = r[15:0];
    e.cout = r[16];
    e.ovf  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: pop/compare on output handshakes, push expectations on accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      ov_hist[cyc % 4096] = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_s", {16'd0, s}, {16'd0, mon_e.s});
          chk("sb_cout", {31'd0, cout}, {31'd0, mon_e.cout});
          chk("sb_ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
          last_s    = s;
          last_cout = cout;
          last_ovf  = ovf;
          last_lat  = cyc - mon_e.cyc;
          got_s.push_back(s);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub, cyc));
        last_acc = cyc;
      end
    end
  end

  task automatic go(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts);
    int n = 0;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input string tag);
    int n = 0;
    while (n_out < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_count"}, n_out, target);
  endtask

  task automatic single(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, input logic [15:0] es, input logic ec,
                        input logic eo, input string tag);
    int base;
    base = n_out;
    go(ta, tb_v, tc, ts);
    wait_out(base + 1, tag);
    chk({tag, "_s"}, {16'd0, last_s}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, last_cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, last_ovf}, {31'd0, eo});
    chk({tag, "_lat"}, last_lat, 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc_x;
    logic [15:0] hold_s;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_s", {16'd0, s}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Full ripple through all four chunks; out_valid must be a 1-cycle pulse.
    single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    chk("ripple_pulse", {31'd0, out_valid}, 32'd0);
    // Carry crossing a chunk boundary, then signed overflow.
    single(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "chunk");
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    // Subtract with borrow, then subtract overflow.
    single(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    // Carry-in and borrow-in.
    single(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin");
    single(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, "sub_cin");

    // Bubbles: input valid pattern 1,0,1,0.
    got_s.delete();
    base = n_out;
    go(16'h0010, 16'h0020, 1'b0, 1'b0);
    acc_x = last_acc;
    @(posedge clk);
    #1;
    go(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_out(base + 2, "bubble");
    repeat (2) @(posedge clk);
    #1;
    chk("bubble_ov0", {31'd0, ov_hist[(acc_x + 4) % 4096]}, 32'd1);
    chk("bubble_ov1", {31'd0, ov_hist[(acc_x + 5) % 4096]}, 32'd0);
    chk("bubble_ov2", {31'd0, ov_hist[(acc_x + 6) % 4096]}, 32'd1);
    chk("bubble_ov3", {31'd0, ov_hist[(acc_x + 7) % 4096]}, 32'd0);
    chk("bubble_s0", {16'd0, got_s[0]}, 32'h0030);
    chk("bubble_s1", {16'd0, got_s[1]}, 32'h2345);

    // Backpressure: 8-deep stream, consumer stalls 3 cycles at first result.
    got_s.delete();
    base = n_out;
    fork
      begin
        for (int i = 1; i <= 8; i++)
          go(16'(i), 16'h0100, 1'b0, (i % 2) == 0);
      end
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        hold_s = s;
        chk("bp_first_s", {16'd0, hold_s}, 32'h0101);
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_s", {16'd0, s}, {16'd0, hold_s});
          chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_out(base + 8, "bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_total", got_s.size(), 32'd8);
    chk("bp_r0", {16'd0, got_s[0]}, 32'h0101);
    chk("bp_r1", {16'd0, got_s[1]}, 32'hFF02);
    chk("bp_r2", {16'd0, got_s[2]}, 32'h0103);
    chk("bp_r7", {16'd0, got_s[7]}, 32'hFF08);

    // Reset with three transactions in flight.
    go(16'h0001, 16'h0001, 1'b0, 1'b0);
    go(16'h0002, 16'h0002, 1'b0, 1'b0);
    go(16'h0003, 16'h0003, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_s", {16'd0, s}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_out;
    single(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, "post_rst");
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_stale", n_out, base + 1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined ripple-chunk adder/subtractor with valid/ready handshakes on input and output.
- Successor to the single-bit combinational half adder: generalised to WIDTH bits, with carry-in, subtract mode, carry-out and signed overflow.
- The carry chain is split into STAGES registered chunks, so it closes timing at board clock on the SP605.
- Sits between a producer of operand pairs and a result consumer; it is used as the arithmetic building block in test designs.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages (1..WIDTH); WIDTH must be divisible by STAGES; CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out (in subtract mode, 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - sub=0: {cout,s} = a + b + cin.
  - sub=1: {cout,s} = a + ~b + ~cin, i.e. s = a − b − cin mod 2^WIDTH.
  - ovf = (opA[MSB] == opB'[MSB]) && (s[MSB] != opA[MSB]), where opB' = b or ~b.
- Pipeline structure:
  - Stage k (0..STAGES−1) adds chunk k of the operands plus the registered carry from stage k−1. Stage 0 uses the effective carry-in: cin, or ~cin when sub=1.
  - Upper operand chunks are skew-delayed so each reaches stage k together with its carry.
  - Lower result chunks are deskew-delayed so all of s appears together.
  - Each stage register holds a valid bit.
- Latency: exactly STAGES cycles from accepting edge (in_valid && in_ready) to out_valid high, when out_ready is held high.
- Throughput: one result per cycle when out_ready is held high.
- Flow control:
  - Global advance enable adv = !out_valid || out_ready.
  - in_ready = adv (combinational); all stage registers, including their valid bits, load only when adv=1.
  - When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
  - Bubbles are not collapsed.
- Output hold: while out_valid=1 && out_ready=0, s/cout/ovf/out_valid hold stable and no transaction is lost or duplicated.
- Ordering: results leave strictly in acceptance order.
- Input sampling: operands and sub/cin are sampled only on an accepting edge. sub and cin travel with their transaction, so mixed add/sub streams are legal back-to-back.
- STAGES=1: single registered adder, latency 1.
- Reset (asynchronous, while rst_n=0):
  - All valid bits, data registers, s, cout and ovf are cleared to 0.
  - in_ready = 1 (since out_valid = 0).
  - Reset asserted mid-operation discards all in-flight transactions. The first result after release corresponds to the first operand accepted after release.
- Simultaneous events: an accept and an output handshake in the same cycle are legal. The pipeline shifts once.

Test Plan (WIDTH=16, STAGES=4):
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → 4 cycles later s=0x0000, cout=1, ovf=0, out_valid pulses 1 cycle.
- Chunk-boundary carry: a=0x0FFF, b=0x0001 → s=0x1000, cout=0, ovf=0. Then a=0x7FFF, b=0x0001 → s=0x8000, ovf=1, cout=0.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 → s=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → s=0x7FFF, ovf=1, cout=1.
- Backpressure: stream a=1..8, b=0x0100, alternating sub, in_valid held high; out_ready low for 3 cycles once the first result appears.
  - Required: s held stable and in_ready=0 while out_ready=0.
  - Required: 8 results exactly, in order (0x0101, 0xFF02, 0x0103, …).
- Bubbles: in_valid toggled 1,0,1,0 → out_valid pattern 1,0,1,0 starting at cycle 4, with correct sums.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight → immediately out_valid=0, s=0, in_ready=1. After release, a=0x0002 + b=0x0003 → s=0x0005 after 4 cycles, with no stale results.
